// File: rtl/core_ibus_bridge_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  core_ibus_if / core_axi_rd_if
//  Bus bundles around the instruction-fetch bridge:
//    core_ibus_if   : icache request/response channel plus the busy indication
//    core_axi_rd_if : AXI4 read-address and read-data channels
//  Revision: 1.0  initial release
// ============================================================================

interface core_ibus_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_addr_i;
   logic        req_uncached_i;
   logic        cancel_i;
   logic        resp_valid_o;
   logic        resp_ready_i;
   logic [31:0] resp_data_o;
   logic        resp_last_o;
   logic        resp_err_o;
   logic        busy_o;

   // icache / frontend side
   modport master (
      output req_valid_i, req_addr_i, req_uncached_i, cancel_i, resp_ready_i,
      input  req_ready_o, resp_valid_o, resp_data_o, resp_last_o, resp_err_o, busy_o
   );

   // bridge side
   modport slave (
      input  req_valid_i, req_addr_i, req_uncached_i, cancel_i, resp_ready_i,
      output req_ready_o, resp_valid_o, resp_data_o, resp_last_o, resp_err_o, busy_o
   );
endinterface

interface core_axi_rd_if;
   logic        arvalid_o;
   logic        arready_i;
   logic [31:0] araddr_o;
   logic [7:0]  arlen_o;
   logic [2:0]  arsize_o;
   logic [1:0]  arburst_o;
   logic [3:0]  arid_o;
   logic        rvalid_i;
   logic        rready_o;
   logic [31:0] rdata_i;
   logic [1:0]  rresp_i;
   logic        rlast_i;
   logic [3:0]  rid_i;

   // bridge side (AXI manager)
   modport master (
      output arvalid_o, araddr_o, arlen_o, arsize_o, arburst_o, arid_o, rready_o,
      input  arready_i, rvalid_i, rdata_i, rresp_i, rlast_i, rid_i
   );

   // interconnect side (AXI subordinate)
   modport slave (
      input  arvalid_o, araddr_o, arlen_o, arsize_o, arburst_o, arid_o, rready_o,
      output arready_i, rvalid_i, rdata_i, rresp_i, rlast_i, rid_i
   );
endinterface

`default_nettype wire

// File: rtl/core_ibus_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  core_ibus_bridge
//  Converts icache line refills / uncached word reads into single AXI4 read
//  bursts, streams the beats back combinationally and silently drains bursts
//  whose request was flushed by the frontend.
//  Revision: 1.0  initial release
// ============================================================================

module core_ibus_bridge #(
   parameter int         LINE_WORDS = 4,
   parameter logic [3:0] AXI_ID     = 4'd0
) (
   input  logic          clk,
   input  logic          rst_n,
   core_ibus_if.slave    ibus,
   core_axi_rd_if.master axi
);

   localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
   localparam logic [31:0] WORD_MASK = ~32'd3;
   localparam logic [7:0]  LINE_LEN  = 8'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      AR    = 2'd1,
      R     = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] araddr_q;
   logic [7:0]  arlen_q;
   logic [3:0]  beat_cnt;
   logic        cancel_pend;

   logic        accept;
   logic        ar_hs;
   logic        r_hs;
   logic        last_beat;
   logic        req_ready;
   logic        arvalid;
   logic        rready;
   logic        resp_valid;
   logic        resp_last;
   logic        resp_err;

   // Beat IDs and RLAST are deliberately ignored; the beat count decides the end.
   logic        unused_r_sideband;
   assign unused_r_sideband = ^{axi.rlast_i, axi.rid_i};

   // Next-state and handshake decode; all outputs idle unless the state drives them.
   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      arvalid    = 1'b0;
      rready     = 1'b0;
      resp_valid = 1'b0;
      resp_last  = 1'b0;
      resp_err   = 1'b0;
      accept     = 1'b0;
      ar_hs      = 1'b0;
      r_hs       = 1'b0;
      last_beat  = ({4'd0, beat_cnt} == arlen_q);
      case (state)
         IDLE: begin
            req_ready = !ibus.cancel_i;
            accept    = ibus.req_valid_i && !ibus.cancel_i;
            if (accept) state_nxt = AR;
         end
         AR: begin
            // arvalid stays up through a cancel; the burst is drained afterwards
            arvalid = 1'b1;
            ar_hs   = axi.arready_i;
            if (ar_hs) state_nxt = (cancel_pend || ibus.cancel_i) ? DRAIN : R;
         end
         R: begin
            resp_valid = axi.rvalid_i;
            rready     = ibus.resp_ready_i;
            resp_last  = last_beat;
            resp_err   = (axi.rresp_i != 2'b00);
            r_hs       = axi.rvalid_i && ibus.resp_ready_i;
            // a last beat taken together with a cancel leaves nothing to drain
            if (r_hs && last_beat)  state_nxt = IDLE;
            else if (ibus.cancel_i) state_nxt = DRAIN;
         end
         DRAIN: begin
            rready = 1'b1;
            r_hs   = axi.rvalid_i;
            if (r_hs && last_beat) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Latched AR fields, beat counter and pending-cancel flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         araddr_q    <= 32'd0;
         arlen_q     <= 8'd0;
         beat_cnt    <= 4'd0;
         cancel_pend <= 1'b0;
      end else begin
         if (accept) begin
            araddr_q <= ibus.req_addr_i & (ibus.req_uncached_i ? WORD_MASK : LINE_MASK);
            arlen_q  <= ibus.req_uncached_i ? 8'd0 : LINE_LEN;
         end
         if (ar_hs)     beat_cnt <= 4'd0;
         else if (r_hs) beat_cnt <= beat_cnt + 4'd1;
         if (state_nxt == IDLE)                    cancel_pend <= 1'b0;
         else if (state == AR && ibus.cancel_i)    cancel_pend <= 1'b1;
      end
   end

   assign ibus.req_ready_o  = req_ready;
   assign ibus.resp_valid_o = resp_valid;
   assign ibus.resp_data_o  = axi.rdata_i;
   assign ibus.resp_last_o  = resp_last;
   assign ibus.resp_err_o   = resp_err;
   assign ibus.busy_o       = (state != IDLE);

   assign axi.arvalid_o = arvalid;
   assign axi.araddr_o  = araddr_q;
   assign axi.arlen_o   = arlen_q;
   assign axi.arsize_o  = 3'b010;
   assign axi.arburst_o = 2'b01;
   assign axi.arid_o    = AXI_ID;
   assign axi.rready_o  = rready;

endmodule

`default_nettype wire

// File: tb/tb_core_ibus_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  tb_core_ibus_bridge
//  Transaction-level model of the bridge plus a small AXI read subordinate;
//  directed scenarios followed by randomized traffic.
//  Revision: 1.0  initial release
// ============================================================================

module tb_core_ibus_bridge;
   localparam int LW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   core_ibus_if   ibus ();
   core_axi_rd_if axi ();

   core_ibus_bridge #(.LINE_WORDS(LW), .AXI_ID(4'd0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ibus  (ibus),
      .axi   (axi)
   );

   int n_checks = 0;
   int n_err    = 0;

   // stimulus knobs
   bit          k_req, k_unc, k_cancel, k_rrdy, k_arrdy, k_rven, rand_err;
   logic [31:0] k_addr;
   logic [31:0] next_dbase;
   int          err_beat  = -1;
   int          cancel_at = -1;

   // transaction model: one request outstanding at most
   bit          m_out, m_ard, m_disc;
   logic [31:0] m_addr, m_dbase;
   logic [7:0]  m_len;
   int          m_beats;

   // AXI subordinate model
   bit          s_act;
   int          s_sent, s_len;
   logic [31:0] s_dbase;

   // observations for literal checks
   logic [31:0] got_d[$];
   bit          got_l[$];
   bit          got_e[$];
   logic [31:0] cap_araddr;
   logic [7:0]  cap_arlen;
   int          n_arv;
   bit          cap_rr;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic clr();
      got_d.delete(); got_l.delete(); got_e.delete();
      cap_araddr = '0; cap_arlen = '0; n_arv = 0; cap_rr = 1'b0;
   endtask

   task automatic knobs_idle();
      k_req = 0; k_unc = 0; k_cancel = 0; k_rrdy = 1; k_arrdy = 1; k_rven = 1;
      rand_err = 0; k_addr = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      knobs_idle();
      ibus.req_valid_i = 0; ibus.req_addr_i = '0; ibus.req_uncached_i = 0;
      ibus.cancel_i = 0; ibus.resp_ready_i = 0;
      axi.arready_i = 0; axi.rvalid_i = 0; axi.rdata_i = '0; axi.rresp_i = '0;
      axi.rlast_i = 0; axi.rid_i = '0;
      repeat (2) @(posedge clk);
      #1;
      m_out = 0; m_ard = 0; m_disc = 0; m_beats = 0; s_act = 0; s_sent = 0;
      chk("rst_busy",       ibus.busy_o,       0);
      chk("rst_req_ready",  ibus.req_ready_o,  1);
      chk("rst_arvalid",    axi.arvalid_o,     0);
      chk("rst_rready",     axi.rready_o,      0);
      chk("rst_resp_valid", ibus.resp_valid_o, 0);
      chk("rst_resp_last",  ibus.resp_last_o,  0);
      chk("rst_resp_err",   ibus.resp_err_o,   0);
      chk("rst_araddr",     axi.araddr_o,      0);
      chk("rst_arlen",      axi.arlen_o,       0);
      rst_n = 1'b1;
   endtask

   // One clock cycle: drive, compare against the model, clock, update model.
   task automatic tick();
      bit cx, rv, e_busy, e_rr, e_arv, e_rrdy, e_rv, acc, arhs, rhs, lastb;
      logic [1:0] rr;
      cx = k_cancel || (cancel_at >= 0 && m_out && m_ard && !m_disc && m_beats == cancel_at);
      rv = s_act && k_rven;
      if (s_sent == err_beat) rr = 2'b10;
      else if (rand_err && $urandom_range(0, 5) == 0) rr = 2'($urandom_range(1, 3));
      else rr = 2'b00;
      ibus.req_valid_i    = k_req;
      ibus.req_addr_i     = k_addr;
      ibus.req_uncached_i = k_unc;
      ibus.cancel_i       = cx;
      ibus.resp_ready_i   = k_rrdy;
      axi.arready_i       = k_arrdy;
      axi.rvalid_i        = rv;
      axi.rdata_i         = s_dbase + 32'(s_sent);
      axi.rresp_i         = rr;
      axi.rlast_i         = s_act && (s_sent == s_len);
      axi.rid_i           = 4'd0;
      #2;
      lastb  = (m_beats == int'(m_len));
      e_busy = m_out;
      e_rr   = !m_out && !cx;
      e_arv  = m_out && !m_ard;
      e_rrdy = m_out && m_ard && (m_disc || k_rrdy);
      e_rv   = m_out && m_ard && !m_disc && rv;
      chk("busy",       ibus.busy_o,       e_busy);
      chk("req_ready",  ibus.req_ready_o,  e_rr);
      chk("arvalid",    axi.arvalid_o,     e_arv);
      chk("rready",     axi.rready_o,      e_rrdy);
      chk("resp_valid", ibus.resp_valid_o, e_rv);
      if (e_arv) begin
         chk("araddr",  axi.araddr_o,  m_addr);
         chk("arlen",   axi.arlen_o,   m_len);
         chk("arsize",  axi.arsize_o,  3'b010);
         chk("arburst", axi.arburst_o, 2'b01);
         chk("arid",    axi.arid_o,    4'd0);
      end
      if (e_rv) begin
         chk("resp_data", ibus.resp_data_o, m_dbase + 32'(m_beats));
         chk("resp_last", ibus.resp_last_o, lastb);
         chk("resp_err",  ibus.resp_err_o,  (rr != 2'b00));
      end
      cap_rr = ibus.req_ready_o;
      if (axi.arvalid_o) begin
         cap_araddr = axi.araddr_o; cap_arlen = axi.arlen_o; n_arv++;
      end
      if (ibus.resp_valid_o && k_rrdy) begin
         got_d.push_back(ibus.resp_data_o);
         got_l.push_back(ibus.resp_last_o);
         got_e.push_back(ibus.resp_err_o);
      end
      acc  = !m_out && k_req && !cx;
      arhs = e_arv && k_arrdy;
      rhs  = e_rrdy && rv;
      @(posedge clk);
      #1;
      if (acc) begin
         m_out = 1; m_ard = 0; m_disc = 0; m_beats = 0;
         m_addr = k_unc ? (k_addr & ~32'h3) : (k_addr & ~32'(LW * 4 - 1));
         m_len  = k_unc ? 8'd0 : 8'(LW - 1);
      end else if (m_out && !m_ard) begin
         if (cx) m_disc = 1;
         if (arhs) begin
            m_ard = 1; m_dbase = next_dbase;
            s_act = 1; s_sent = 0; s_len = int'(m_len); s_dbase = next_dbase;
         end
      end else if (m_out) begin
         if (rhs && lastb) m_out = 0;
         else begin
            if (rhs) m_beats++;
            if (cx) m_disc = 1;
         end
      end
      if (rhs) begin
         s_sent++;
         if (s_sent > s_len) s_act = 0;
      end
   endtask

   task automatic issue(input logic [31:0] addr, input bit unc);
      k_req = 1; k_addr = addr; k_unc = unc;
      tick();
      k_req = 0;
   endtask

   task automatic run_idle(input int maxc);
      int c = 0;
      while (m_out && c < maxc) begin
         tick();
         c++;
      end
      if (m_out) begin
         n_checks++; n_err++;
         $display("FAIL timeout: actual=busy required=idle within %0d cycles", maxc);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int p, c;
      do_reset();

      // cached refill
      clr(); next_dbase = 32'hA0;
      issue(32'h1C00_0014, 0);
      run_idle(50);
      chk("refill_araddr", cap_araddr, 32'h1C00_0010);
      chk("refill_arlen",  cap_arlen,  8'd3);
      chk("refill_nbeats", got_d.size(), 4);
      for (int i = 0; i < got_d.size() && i < 4; i++) begin
         chk("refill_data", got_d[i], 32'hA0 + 32'(i));
         chk("refill_last", got_l[i], (i == 3));
      end

      // uncached read
      clr(); next_dbase = 32'h5500;
      issue(32'hBFD0_0003, 1);
      run_idle(50);
      chk("unc_araddr", cap_araddr, 32'hBFD0_0000);
      chk("unc_arlen",  cap_arlen,  8'd0);
      chk("unc_nbeats", got_d.size(), 1);
      if (got_l.size() > 0) chk("unc_last", got_l[0], 1);

      // backpressure 1,0,0,1 with rvalid held high
      clr(); next_dbase = 32'hA0;
      issue(32'h0000_1000, 0);
      p = 0; c = 0;
      while (m_out && c < 60) begin
         if (m_ard) begin
            k_rrdy = (p % 4 == 0) || (p % 4 == 3);
            p++;
         end else k_rrdy = 1;
         tick();
         c++;
      end
      k_rrdy = 1;
      run_idle(10);
      chk("bp_nbeats", got_d.size(), 4);
      for (int i = 0; i < got_d.size() && i < 4; i++)
         chk("bp_data", got_d[i], 32'hA0 + 32'(i));

      // cancel while AR is stalled
      clr(); next_dbase = 32'h77;
      k_arrdy = 0;
      issue(32'h2000_0040, 0);
      k_cancel = 1; tick(); k_cancel = 0;
      tick(); tick();
      k_arrdy = 1; k_rrdy = 0;
      run_idle(50);
      k_rrdy = 1;
      chk("car_ar_cycles", n_arv, 4);
      chk("car_delivered", got_d.size(), 0);

      // cancel on the beat-1 handshake, then a fresh request
      clr(); next_dbase = 32'hB0;
      cancel_at = 1;
      issue(32'h3000_0000, 0);
      run_idle(50);
      cancel_at = -1;
      chk("cmid_delivered", got_d.size(), 2);
      if (got_d.size() > 1) chk("cmid_beat1", got_d[1], 32'hB1);
      clr(); next_dbase = 32'hD0;
      issue(32'h0000_1236, 1);
      run_idle(50);
      chk("cmid_next_addr", cap_araddr, 32'h0000_1234);

      // error response on beat 2
      clr(); next_dbase = 32'hC0; err_beat = 2;
      issue(32'h4000_0020, 0);
      run_idle(50);
      err_beat = -1;
      chk("err_nbeats", got_e.size(), 4);
      for (int i = 0; i < got_e.size(); i++) chk("err_flag", got_e[i], (i == 2));

      // request together with cancel in IDLE
      clr();
      k_req = 1; k_cancel = 1; k_addr = 32'h5000_0000;
      tick();
      chk("idle_cancel_ready", cap_rr, 0);
      k_req = 0; k_cancel = 0;
      tick(); tick();
      chk("idle_cancel_no_ar", n_arv, 0);

      // reset in the middle of a burst
      next_dbase = 32'hE0;
      issue(32'h6000_0000, 0);
      tick(); tick(); tick();
      do_reset();

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if (!m_out) next_dbase = $urandom;
         k_req    = ($urandom_range(0, 1) == 1);
         k_addr   = $urandom;
         k_unc    = ($urandom_range(0, 2) == 0);
         k_cancel = ($urandom_range(0, 15) == 0);
         k_arrdy  = ($urandom_range(0, 2) != 0);
         k_rven   = ($urandom_range(0, 3) != 0);
         k_rrdy   = ($urandom_range(0, 3) != 0);
         rand_err = 1;
         tick();
      end
      knobs_idle();
      run_idle(200);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/core_ibus_bridge.md
# core_ibus_bridge

Memory-side responder for the instruction-fetch cache bus. It accepts cacheline refill requests and uncached single-word reads from the icache and converts each one into an AXI4 read transaction. Returned beats stream back to the icache, and the bridge absorbs frontend flushes without violating AXI. It sits between the frontend fetch unit and the SoC AXI interconnect, and drives the frontend's bus-busy indication.

## Interface
Parameters:
- LINE_WORDS, 4: 32-bit words per cacheline; power of two, 1..16; cached burst length.
- AXI_ID, 4'd0: constant ARID driven on every transaction.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  icache read request valid.
- req_ready_o  out  1  bridge accepts a request this cycle.
- req_addr_i  in  32  physical address.
- req_uncached_i  in  1  1 = single-word read; 0 = line refill.
- cancel_i  in  1  flush; discard the outstanding request's data (frontend rst_jmp).
- resp_valid_o  out  1  data beat valid to the icache.
- resp_ready_i  in  1  icache accepts the beat.
- resp_data_o  out  32  beat data.
- resp_last_o  out  1  final beat of the current request.
- resp_err_o  out  1  beat returned with RRESP != OKAY.
- busy_o  out  1  transaction in flight (state != IDLE).
- arvalid_o/arready_i/araddr_o[31:0]/arlen_o[7:0]/arsize_o[2:0]/arburst_o[1:0]/arid_o[3:0]: AXI4 AR channel.
- rvalid_i/rready_o/rdata_i[31:0]/rresp_i[1:0]/rlast_i/rid_i[3:0]: AXI4 R channel.

## Operation
- States: IDLE, AR, R, DRAIN.
- **IDLE**
  - req_ready_o = !cancel_i.
  - On req_valid_i & req_ready_o: latch the address and mode, then go to AR.
  - Cached address: req_addr_i with the low log2(LINE_WORDS*4) bits cleared; arlen = LINE_WORDS-1.
  - Uncached address: req_addr_i with bits [1:0] cleared; arlen = 0.
  - Both modes: arsize = 3'b010, arburst = 2'b01 (INCR), arid = AXI_ID.
- **AR**
  - arvalid_o = 1; AR fields are stable until the handshake.
  - Once arvalid_o is high it never drops before arready_i, even on cancel.
  - On handshake: go to R, or to DRAIN if a cancel is pending or cancel_i is high this cycle.
- **R**
  - resp_valid_o = rvalid_i; rready_o = resp_ready_i.
  - resp_data_o = rdata_i; resp_err_o = (rresp_i != 2'b00).
  - resp_last_o = (beat_cnt == latched arlen). beat_cnt is 4 bits and clears on entry to R.
  - beat_cnt increments on each rvalid_i & rready_o.
  - On the last-beat handshake: go to IDLE.
  - cancel_i in R: go to DRAIN next cycle. A beat handshaking in the cancel cycle is still delivered.
- **DRAIN**
  - rready_o = 1; resp_valid_o = 0.
  - Count the remaining beats; on the last beat go to IDLE.
- Cancel pending flag: set by cancel_i in AR; cleared on entry to IDLE.
- rlast_i and rid_i are not used for control; the beat count is authoritative.
- Simultaneous events:
  - Last-beat handshake in R plus cancel_i: go to IDLE. The beat is delivered; there is nothing left to drain.
  - req_valid_i plus cancel_i in IDLE: the request is not accepted.

## Timing
- Reset values:
  - State IDLE.
  - arvalid_o 0, rready_o 0, resp_valid_o 0, resp_last_o 0, resp_err_o 0, busy_o 0.
  - req_ready_o 1 (when cancel_i = 0).
  - AR field registers 0; beat_cnt 0; cancel pending 0.
- Request accepted in cycle T → arvalid_o high in T+1 (registered).
- The R path is combinational pass-through with zero added latency; rvalid_i → resp_valid_o in the same cycle.
- Last beat handshakes in cycle T → IDLE in T+1, req_ready_o high in T+1. Back-to-back throughput is at most one request per (burst + 2) cycles.
- Reset mid-transaction returns to IDLE immediately. The AXI slave must be reset concurrently; no drain is performed.

## Test plan
- **Cached refill.** req addr 0x1C00_0014, uncached=0, LINE_WORDS=4, arready immediate, data 0xA0..0xA3.
  - Required: araddr 0x1C00_0010, arlen 3, arburst 01, arsize 010.
  - Required: 4 resp beats in order, resp_last_o only on 0xA3, busy_o falls the cycle after the last beat.
- **Uncached read.** Addr 0xBFD0_0003.
  - Required: araddr 0xBFD0_0000, arlen 0, single beat with resp_last_o = 1.
- **Backpressure.** resp_ready_i toggles 1,0,0,1 while rvalid_i is held high.
  - Required: rready_o mirrors resp_ready_i.
  - Required: no beat is lost or duplicated; beat_cnt advances only on handshakes.
- **Cancel in AR.** arready_i held 0 for 3 cycles, cancel_i pulsed in cycle 1.
  - Required: arvalid_o stays high until the handshake; state goes to DRAIN.
  - Required: rready_o = 1 for all 4 beats, resp_valid_o stays 0, then IDLE.
- **Cancel mid-burst.** Cancel pulsed on the cycle beat 1 handshakes.
  - Required: beat 1 is delivered; beats 2–3 are drained silently.
  - Required: a new request issued after IDLE gets its correct address.
- **Error and simultaneous events.**
  - rresp = 2'b10 on beat 2 → resp_err_o high on that beat only.
  - req_valid_i together with cancel_i in IDLE → req_ready_o = 0 and no AR is issued.
